selector_campos: RTL and testbench

Button front-end and edit-mode controller for the clock/date/timer display. It conditions five raw push-buttons: synchronizes, debounces and edge-detects them, and auto-repeats up/down. It runs the field-selection state machine that drives `contadoresH` and issues single-cycle `Arriba`/`Abajo` pulses. It sits directly upstream of every adjustable counter, including the timer-seconds counter, which responds when `contadoresH == 8`.

---
 rtl/reloj_pkg.sv | 20 ++
 rtl/antirrebote.sv | 64 ++++++
 rtl/selector_campos.sv | 174 +++++++++++++++++
 tb/tb_selector_campos.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reloj_pkg.sv
// Shared field codes and edit-mode state encoding for the clock/date/timer
// display front-end.
package reloj_pkg;

    localparam logic [3:0] CAMPO_NINGUNO = 4'd0;
    localparam logic [3:0] CAMPO_HORA    = 4'd1;
    localparam logic [3:0] CAMPO_MIN     = 4'd2;
    localparam logic [3:0] CAMPO_SEG     = 4'd3;
    localparam logic [3:0] CAMPO_DIA     = 4'd4;
    localparam logic [3:0] CAMPO_MES     = 4'd5;
    localparam logic [3:0] CAMPO_T_HORA  = 4'd6;
    localparam logic [3:0] CAMPO_T_MIN   = 4'd7;
    localparam logic [3:0] CAMPO_T_SEG   = 4'd8;

    typedef enum logic {
        ESTADO_IDLE = 1'b0,
        ESTADO_EDIT = 1'b1
    } estado_t;

endpackage

// File: rtl/antirrebote.sv
// One push-button conditioner: 2-FF synchronizer, counting debouncer and
// a registered one-cycle pulse on each accepted rising edge.
module antirrebote
    import reloj_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic nivel,
    output logic pulso
);

    localparam int CNT_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEB_CYCLES - 1);

    logic             sinc1_q, sinc1_d;
    logic             sinc2_q, sinc2_d;
    logic             nivel_q, nivel_d;
    logic             nivel_ant_q, nivel_ant_d;
    logic             pulso_q, pulso_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sinc1_d     = btn;
        sinc2_d     = sinc1_q;
        nivel_d     = nivel_q;
        cnt_d       = '0;
        nivel_ant_d = nivel_q;
        pulso_d     = nivel_q & ~nivel_ant_q;
        // The counter only advances while the synchronized input disagrees;
        // it is cleared on flip, so it never exceeds DEB_CYCLES-1.
        if (sinc2_q != nivel_q) begin
            if (cnt_q >= CNT_ULTIMO) begin
                nivel_d = sinc2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sinc1_q     <= 1'b0;
            sinc2_q     <= 1'b0;
            nivel_q     <= 1'b0;
            nivel_ant_q <= 1'b0;
            pulso_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sinc1_q     <= sinc1_d;
            sinc2_q     <= sinc2_d;
            nivel_q     <= nivel_d;
            nivel_ant_q <= nivel_ant_d;
            pulso_q     <= pulso_d;
            cnt_q       <= cnt_d;
        end
    end

    assign nivel = nivel_q;
    assign pulso = pulso_q;

endmodule

// File: rtl/selector_campos.sv
// Edit-mode controller: conditions five buttons, auto-repeats up/down and
// walks the selected field, emitting one-cycle Arriba/Abajo pulses.
module selector_campos
    import reloj_pkg::*;
#(
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 25_000_000,
    parameter int NUM_FIELDS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_editar,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic [3:0] contadoresH,
    output logic       Arriba,
    output logic       Abajo,
    output logic       editando
);

    localparam int BTN_EDITAR = 0;
    localparam int BTN_IZQ    = 1;
    localparam int BTN_DER    = 2;
    localparam int BTN_ARRIBA = 3;
    localparam int BTN_ABAJO  = 4;

    localparam int DEL_W  = $clog2(REPEAT_DELAY) + 1;
    localparam int PER_W  = $clog2(REPEAT_PERIOD) + 1;
    localparam int HOLD_W = (DEL_W > PER_W) ? DEL_W : PER_W;
    localparam logic [HOLD_W-1:0] UMBRAL_RETARDO = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] UMBRAL_PERIODO = HOLD_W'(REPEAT_PERIOD - 1);
    localparam logic [3:0]        CAMPO_ULTIMO   = 4'(NUM_FIELDS);

    logic [4:0] botones;
    logic [4:0] nivel_v;
    logic [4:0] pulso_v;
    logic       niveles_unused;

    assign botones = {btn_abajo, btn_arriba, btn_der, btn_izq, btn_editar};

    for (genvar g = 0; g < 5; g++) begin : g_btn
        antirrebote #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_antirrebote (
            .clk  (clk),
            .reset(reset),
            .btn  (botones[g]),
            .nivel(nivel_v[g]),
            .pulso(pulso_v[g])
        );
    end

    // Only up/down need their held level, for auto-repeat.
    assign niveles_unused = ^nivel_v[BTN_DER:BTN_EDITAR];

    // Auto-repeat, index 0 = arriba, 1 = abajo. hold counts cycles since the
    // last press/repeat event; modo selects initial delay vs. repeat period.
    logic [1:0]        nivel_ud, pulso_ud;
    logic [HOLD_W-1:0] hold_q [2];
    logic [HOLD_W-1:0] hold_d [2];
    logic [1:0]        modo_q, modo_d;
    logic [1:0]        rep_q, rep_d;

    assign nivel_ud = {nivel_v[BTN_ABAJO], nivel_v[BTN_ARRIBA]};
    assign pulso_ud = {pulso_v[BTN_ABAJO], pulso_v[BTN_ARRIBA]};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hold_d[i] = hold_q[i];
            modo_d[i] = modo_q[i];
            rep_d[i]  = 1'b0;
            if (!nivel_ud[i]) begin
                hold_d[i] = '0;
                modo_d[i] = 1'b0;
            end else if (pulso_ud[i]) begin
                hold_d[i] = HOLD_W'(1);
                modo_d[i] = 1'b0;
            end else if (rep_q[i]) begin
                hold_d[i] = HOLD_W'(1);
                modo_d[i] = 1'b1;
            end else if (hold_q[i] != '0) begin
                if (hold_q[i] == (modo_q[i] ? UMBRAL_PERIODO : UMBRAL_RETARDO)) begin
                    rep_d[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    logic ev_editar, ev_izq, ev_der, ev_arriba, ev_abajo;

    assign ev_editar = pulso_v[BTN_EDITAR];
    assign ev_izq    = pulso_v[BTN_IZQ];
    assign ev_der    = pulso_v[BTN_DER];
    assign ev_arriba = pulso_ud[0] | rep_q[0];
    assign ev_abajo  = pulso_ud[1] | rep_q[1];

    estado_t    estado_q, estado_d;
    logic [3:0] campo_q, campo_d;
    logic       arriba_q, arriba_d;
    logic       abajo_q, abajo_d;
    logic       editando_q, editando_d;

    always_comb begin
        estado_d = estado_q;
        campo_d  = campo_q;
        arriba_d = 1'b0;
        abajo_d  = 1'b0;
        case (estado_q)
            ESTADO_IDLE: begin
                campo_d = CAMPO_NINGUNO;
                if (ev_editar) begin
                    estado_d = ESTADO_EDIT;
                    campo_d  = CAMPO_HORA;
                end
            end
            ESTADO_EDIT: begin
                if (ev_editar) begin
                    estado_d = ESTADO_IDLE;
                    campo_d  = CAMPO_NINGUNO;
                end else begin
                    if (ev_der && !ev_izq) begin
                        campo_d = (campo_q >= CAMPO_ULTIMO) ? CAMPO_HORA : campo_q + 4'd1;
                    end else if (ev_izq && !ev_der) begin
                        campo_d = (campo_q <= CAMPO_HORA) ? CAMPO_ULTIMO : campo_q - 4'd1;
                    end
                    arriba_d = ev_arriba & ~ev_abajo;
                    abajo_d  = ev_abajo & ~ev_arriba;
                end
            end
            default: begin
                estado_d = ESTADO_IDLE;
                campo_d  = CAMPO_NINGUNO;
            end
        endcase
        editando_d = (estado_d == ESTADO_EDIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                hold_q[i] <= '0;
            end
            modo_q     <= '0;
            rep_q      <= '0;
            estado_q   <= ESTADO_IDLE;
            campo_q    <= CAMPO_NINGUNO;
            arriba_q   <= 1'b0;
            abajo_q    <= 1'b0;
            editando_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                hold_q[i] <= hold_d[i];
            end
            modo_q     <= modo_d;
            rep_q      <= rep_d;
            estado_q   <= estado_d;
            campo_q    <= campo_d;
            arriba_q   <= arriba_d;
            abajo_q    <= abajo_d;
            editando_q <= editando_d;
        end
    end

    assign contadoresH = campo_q;
    assign Arriba      = arriba_q;
    assign Abajo       = abajo_q;
    assign editando    = editando_q;

endmodule

// File: tb/tb_selector_campos.sv
// Directed bench for selector_campos with short debounce/repeat parameters.
module tb_selector_campos;

    logic       clk;
    logic       reset;
    logic       btn_editar, btn_izq, btn_der, btn_arriba, btn_abajo;
    logic [3:0] contadoresH;
    logic       Arriba, Abajo, editando;

    selector_campos #(
        .DEB_CYCLES   (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8),
        .NUM_FIELDS   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_editar (btn_editar),
        .btn_izq    (btn_izq),
        .btn_der    (btn_der),
        .btn_arriba (btn_arriba),
        .btn_abajo  (btn_abajo),
        .contadoresH(contadoresH),
        .Arriba     (Arriba),
        .Abajo      (Abajo),
        .editando   (editando)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Button masks {editar, izq, der, arriba, abajo}
    localparam logic [4:0] M_ED = 5'b10000;
    localparam logic [4:0] M_IZ = 5'b01000;
    localparam logic [4:0] M_DE = 5'b00100;
    localparam logic [4:0] M_AR = 5'b00010;
    localparam logic [4:0] M_AB = 5'b00001;

    typedef struct {
        logic [4:0] btns;
        int         campo;
        int         edit;
        int         up;
        int         dn;
    } vec_t;

    vec_t tabla [19];

    int checks = 0;
    int errors = 0;
    int both_hi = 0;
    int zero_pulse = 0;
    int cambios = 0;
    int prev_campo = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] m);
        {btn_editar, btn_izq, btn_der, btn_arriba, btn_abajo} = m;
    endtask

    task automatic ciclos(input int n, inout int up, inout int dn);
        repeat (n) begin
            @(posedge clk);
            #1;
            up += int'(Arriba);
            dn += int'(Abajo);
            if (Arriba && Abajo) both_hi++;
            if ((Arriba || Abajo) && contadoresH == 4'd0) zero_pulse++;
            if (int'(contadoresH) != prev_campo) cambios++;
            prev_campo = int'(contadoresH);
        end
    endtask

    task automatic pulsar(input logic [4:0] m);
        int u, d;
        u = 0;
        d = 0;
        drive(m);
        ciclos(8, u, d);
        drive(5'b0);
        ciclos(12, u, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int  up, dn, early;
        logic exp_pulse;

        tabla[0]  = '{M_ED, 0, 0, 0, 0};
        tabla[1]  = '{M_ED, 1, 1, 0, 0};
        tabla[2]  = '{M_DE, 2, 1, 0, 0};
        tabla[3]  = '{M_DE, 3, 1, 0, 0};
        tabla[4]  = '{M_DE, 4, 1, 0, 0};
        tabla[5]  = '{M_DE, 5, 1, 0, 0};
        tabla[6]  = '{M_DE, 6, 1, 0, 0};
        tabla[7]  = '{M_DE, 7, 1, 0, 0};
        tabla[8]  = '{M_DE, 8, 1, 0, 0};
        tabla[9]  = '{M_DE, 1, 1, 0, 0};
        tabla[10] = '{M_IZ, 8, 1, 0, 0};
        tabla[11] = '{M_AB, 8, 1, 0, 1};
        tabla[12] = '{M_AR, 8, 1, 1, 0};
        tabla[13] = '{M_AR | M_AB, 8, 1, 0, 0};
        tabla[14] = '{M_ED, 0, 0, 0, 0};
        tabla[15] = '{M_AR, 0, 0, 0, 0};
        tabla[16] = '{M_ED, 1, 1, 0, 0};
        tabla[17] = '{M_DE, 2, 1, 0, 0};
        tabla[18] = '{M_ED | M_DE, 0, 0, 0, 0};

        up = 0;
        dn = 0;
        reset = 1'b1;
        drive(5'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_campo", int'(contadoresH), 0);
        check("reset_arriba", int'(Arriba), 0);
        check("reset_abajo", int'(Abajo), 0);
        check("reset_editando", int'(editando), 0);
        #3 reset = 1'b0;
        ciclos(3, up, dn);

        // Press latency: outputs change exactly 8 cycles after the input rises
        early = 0;
        drive(M_ED);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8 && (editando || contadoresH != 4'd0)) early++;
        end
        check("lat_early", early, 0);
        check("lat_editando", int'(editando), 1);
        check("lat_campo", int'(contadoresH), 1);
        drive(5'b0);
        ciclos(12, up, dn);

        for (int i = 0; i < 19; i++) begin
            up = 0;
            dn = 0;
            drive(tabla[i].btns);
            ciclos(8, up, dn);
            check($sformatf("vec%0d_campo", i), int'(contadoresH), tabla[i].campo);
            check($sformatf("vec%0d_editando", i), int'(editando), tabla[i].edit);
            drive(5'b0);
            ciclos(12, up, dn);
            check($sformatf("vec%0d_arriba_cnt", i), up, tabla[i].up);
            check($sformatf("vec%0d_abajo_cnt", i), dn, tabla[i].dn);
        end

        // Bouncing der: one accepted press, one field step
        pulsar(M_ED);
        check("bounce_start", int'(contadoresH), 1);
        cambios = 0;
        prev_campo = int'(contadoresH);
        for (int i = 0; i < 5; i++) begin
            drive(M_DE);
            ciclos(2, up, dn);
            drive(5'b0);
            ciclos(2, up, dn);
        end
        drive(M_DE);
        ciclos(16, up, dn);
        drive(5'b0);
        ciclos(12, up, dn);
        check("bounce_changes", cambios, 1);
        check("bounce_campo", int'(contadoresH), 2);

        // Held arriba on the last field: press pulse then repeat train
        pulsar(M_IZ);
        pulsar(M_IZ);
        check("hold_campo", int'(contadoresH), 8);
        dn = 0;
        drive(M_AR);
        for (int k = 1; k <= 59; k++) begin
            @(posedge clk);
            #1;
            exp_pulse = (k == 8) || (k == 28) || (k == 36) || (k == 44) || (k == 52);
            check($sformatf("hold_arriba_k%0d", k), int'(Arriba), int'(exp_pulse));
            dn += int'(Abajo);
            if (contadoresH != 4'd8) zero_pulse++;
        end
        check("hold_abajo_cnt", dn, 0);
        drive(5'b0);
        ciclos(20, up, dn);

        // Reset mid-repeat, button still held afterwards
        up = 0;
        drive(M_AR);
        ciclos(28, up, dn);
        check("prereset_arriba", int'(Arriba), 1);
        #1 reset = 1'b1;
        #1;
        check("midreset_arriba", int'(Arriba), 0);
        check("midreset_abajo", int'(Abajo), 0);
        check("midreset_campo", int'(contadoresH), 0);
        check("midreset_editando", int'(editando), 0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        up = 0;
        dn = 0;
        ciclos(40, up, dn);
        check("postreset_arriba_cnt", up, 0);
        check("postreset_editando", int'(editando), 0);
        check("postreset_campo", int'(contadoresH), 0);
        drive(5'b0);
        ciclos(12, up, dn);

        check("never_both_pulses", both_hi, 0);
        check("no_pulse_field0", zero_pulse, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
